// File: rtl/stopwatch_time_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_time_counter
//   Divides clk into centisecond ticks and counts elapsed time as BCD MM:SS.cc.
//   A lap pulse freezes the displayed value on a latched copy while the live
//   count keeps running; a second lap pulse returns the display to live time.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   run        count enable from the stopwatch controller
//   clr        synchronous clear (level), highest priority
//   lap        single-cycle lap toggle pulse
//   min_tens .. cs_ones   displayed BCD digits (lap latch or live)
//   lap_active high while the display shows the lap latch
//   overflow   sticky, set when the count wraps past 59:59.99
// -----------------------------------------------------------------------------
module stopwatch_time_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       clr,
  input  logic       lap,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       lap_active,
  output logic       overflow
);

  localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
  localparam int REM = (TICK_HZ > 0) ? (CLK_HZ % TICK_HZ) : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  generate
    if (DIV < 1 || REM != 0) begin : g_bad_cfg
      $error("stopwatch_time_counter: CLK_HZ/TICK_HZ must be an integer >= 1");
    end
  endgenerate

  logic [PW-1:0] r_presc;
  logic [3:0]    r_cs_ones, r_cs_tens, r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
  logic [23:0]   r_lap;
  logic          r_lap_active;
  logic          r_overflow;

  logic          w_tick;
  logic          w_c0, w_c1, w_c2, w_c3, w_c4, w_wrap;
  logic [23:0]   w_live;
  logic [23:0]   w_disp;

  assign w_tick = run && (r_presc == DIV_LAST);

  // Ripple carry chain, all resolved combinationally so one edge updates
  // every digit.
  assign w_c0   = (r_cs_ones  == 4'd9);
  assign w_c1   = w_c0 && (r_cs_tens  == 4'd9);
  assign w_c2   = w_c1 && (r_sec_ones == 4'd9);
  assign w_c3   = w_c2 && (r_sec_tens == 4'd5);
  assign w_c4   = w_c3 && (r_min_ones == 4'd9);
  assign w_wrap = w_c4 && (r_min_tens == 4'd5);

  assign w_live = {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones, r_cs_tens, r_cs_ones};
  assign w_disp = r_lap_active ? r_lap : w_live;

  assign min_tens   = w_disp[23:20];
  assign min_ones   = w_disp[19:16];
  assign sec_tens   = w_disp[15:12];
  assign sec_ones   = w_disp[11:8];
  assign cs_tens    = w_disp[7:4];
  assign cs_ones    = w_disp[3:0];
  assign lap_active = r_lap_active;
  assign overflow   = r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_cs_ones    <= 4'd0;
      r_cs_tens    <= 4'd0;
      r_sec_ones   <= 4'd0;
      r_sec_tens   <= 4'd0;
      r_min_ones   <= 4'd0;
      r_min_tens   <= 4'd0;
      r_lap        <= '0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (clr) begin
      r_presc      <= '0;
      r_cs_ones    <= 4'd0;
      r_cs_tens    <= 4'd0;
      r_sec_ones   <= 4'd0;
      r_sec_tens   <= 4'd0;
      r_min_ones   <= 4'd0;
      r_min_tens   <= 4'd0;
      r_lap        <= '0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      // Prescaler holds while paused so the partial tick survives a resume.
      if (run) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      if (w_tick) begin
        r_cs_ones <= w_c0 ? 4'd0 : r_cs_ones + 4'd1;
        if (w_c0) r_cs_tens  <= w_c1   ? 4'd0 : r_cs_tens  + 4'd1;
        if (w_c1) r_sec_ones <= w_c2   ? 4'd0 : r_sec_ones + 4'd1;
        if (w_c2) r_sec_tens <= w_c3   ? 4'd0 : r_sec_tens + 4'd1;
        if (w_c3) r_min_ones <= w_c4   ? 4'd0 : r_min_ones + 4'd1;
        if (w_c4) r_min_tens <= w_wrap ? 4'd0 : r_min_tens + 4'd1;
        if (w_wrap) r_overflow <= 1'b1;
      end
      // The latch samples the pre-edge live value, so a lap coinciding with
      // a tick captures the value before that tick.
      if (lap) begin
        if (!r_lap_active) begin
          r_lap        <= w_live;
          r_lap_active <= 1'b1;
        end else begin
          r_lap_active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
module tb_stopwatch_time_counter;

  localparam int CLK_HZ  = 400;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int WRAP    = 360000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run, clr, lap;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;
  logic       lap_active, overflow;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: elapsed enabled edges since clear; time is derived by
  // integer division, lap state kept as an integer centisecond value.
  int m_en    = 0;
  bit m_lapact = 1'b0;
  int m_lapv  = 0;

  stopwatch_time_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clr(clr), .lap(lap),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .cs_tens(cs_tens), .cs_ones(cs_ones),
    .lap_active(lap_active), .overflow(overflow)
  );

  always #5 clk = ~clk;

  wire [23:0] dut_disp = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};

  function automatic logic [23:0] to_bcd(int v);
    int mm, ss, cc;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic int m_live();
    return (m_en / DIV) % WRAP;
  endfunction

  function automatic bit m_ovf();
    return (m_en / DIV) >= WRAP;
  endfunction

  function automatic logic [23:0] m_disp();
    return m_lapact ? to_bcd(m_lapv) : to_bcd(m_live());
  endfunction

  task automatic model_reset();
    m_en = 0; m_lapact = 1'b0; m_lapv = 0;
  endtask

  task automatic model_step(bit r, bit c, bit l);
    if (c) begin
      model_reset();
    end else begin
      if (l) begin
        if (!m_lapact) begin m_lapv = m_live(); m_lapact = 1'b1; end
        else m_lapact = 1'b0;
      end
      if (r) m_en++;
    end
  endtask

  task automatic cycle(bit r, bit c, bit l);
    run = r; clr = c; lap = l;
    @(posedge clk);
    model_step(r, c, l);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; clr = 1'b0; lap = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1; model_reset();
    n_total++;
    if (dut_disp !== 24'h0 || lap_active !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_init: disp=%h lap=%b ovf=%b want 000000 0 0", dut_disp, lap_active, overflow);
    end
    repeat (7) cycle(1, 0, 0);
    @(negedge clk); reset_n = 1'b0; #1;
    n_total++;
    if (dut_disp !== 24'h0) begin
      n_bad++; $display("FAIL reset_async: disp=%h want 000000", dut_disp);
    end
    run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1; model_reset();
    for (int i = 1; i <= DIV; i++) begin
      cycle(1, 0, 0);
      n_total++;
      if (dut_disp !== ((i == DIV) ? 24'h1 : 24'h0) || lap_active !== 1'b0 || overflow !== 1'b0) begin
        n_bad++; $display("FAIL reset_first_tick: cyc=%0d disp=%h lap=%b ovf=%b", i, dut_disp, lap_active, overflow);
      end
    end
  endtask

  task automatic test_basic_count();
    cycle(0, 1, 0);
    repeat (400) cycle(1, 0, 0);
    n_total++;
    if (dut_disp !== 24'h000100 || dut_disp !== m_disp()) begin
      n_bad++; $display("FAIL basic_1s: disp=%h want 000100", dut_disp);
    end
    repeat (6000 * DIV - 400) cycle(1, 0, 0);
    n_total++;
    if (dut_disp !== 24'h010000 || lap_active !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL basic_1min: disp=%h lap=%b ovf=%b want 010000 0 0", dut_disp, lap_active, overflow);
    end
  endtask

  task automatic test_pause_resume();
    cycle(0, 1, 0);
    repeat (6)  cycle(1, 0, 0);
    repeat (20) cycle(0, 0, 0);
    n_total++;
    if (dut_disp !== 24'h000001) begin
      n_bad++; $display("FAIL pause_hold: disp=%h want 000001", dut_disp);
    end
    repeat (2) cycle(1, 0, 0);
    n_total++;
    if (cs_ones !== 4'd2 || dut_disp !== m_disp()) begin
      n_bad++; $display("FAIL pause_resume: cs_ones=%0d want 2", cs_ones);
    end
  endtask

  task automatic test_rollover();
    cycle(0, 1, 0);
    repeat (2) cycle(1, 0, 0);
    cycle(0, 0, 0);
    // Jump the live digits to 59:59.98 instead of spending 1.44M cycles.
    force dut.r_min_tens = 4'd5; force dut.r_min_ones = 4'd9;
    force dut.r_sec_tens = 4'd5; force dut.r_sec_ones = 4'd9;
    force dut.r_cs_tens  = 4'd9; force dut.r_cs_ones  = 4'd8;
    cycle(0, 0, 0);
    release dut.r_min_tens; release dut.r_min_ones;
    release dut.r_sec_tens; release dut.r_sec_ones;
    release dut.r_cs_tens;  release dut.r_cs_ones;
    m_en = (WRAP - 2) * DIV + (m_en % DIV);
    cycle(0, 0, 0);
    n_total++;
    if (dut_disp !== 24'h595998) begin
      n_bad++; $display("FAIL roll_preset: disp=%h want 595998", dut_disp);
    end
    repeat (2) cycle(1, 0, 0);
    n_total++;
    if (dut_disp !== 24'h595999 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL roll_max: disp=%h ovf=%b want 595999 0", dut_disp, overflow);
    end
    repeat (DIV) cycle(1, 0, 0);
    n_total++;
    if (dut_disp !== 24'h000000 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL roll_wrap: disp=%h ovf=%b want 000000 1", dut_disp, overflow);
    end
    repeat (3 * DIV) cycle(1, 0, 0);
    n_total++;
    if (overflow !== 1'b1 || dut_disp !== m_disp() || overflow !== m_ovf()) begin
      n_bad++; $display("FAIL roll_sticky: disp=%h ovf=%b want %h 1", dut_disp, overflow, m_disp());
    end
    cycle(1, 1, 0);
    n_total++;
    if (overflow !== 1'b0 || dut_disp !== 24'h0) begin
      n_bad++; $display("FAIL roll_clr: disp=%h ovf=%b want 000000 0", dut_disp, overflow);
    end
  endtask

  task automatic test_lap();
    cycle(0, 1, 0);
    repeat (5 * DIV) cycle(1, 0, 0);
    cycle(1, 0, 1);
    for (int i = 0; i < 10 * DIV; i++) begin
      n_total++;
      if (dut_disp !== 24'h000005 || lap_active !== 1'b1) begin
        n_bad++; $display("FAIL lap_freeze: cyc=%0d disp=%h lap=%b want 000005 1", i, dut_disp, lap_active);
      end
      cycle(1, 0, 0);
    end
    cycle(1, 0, 1);
    n_total++;
    if (dut_disp !== 24'h000015 || lap_active !== 1'b0) begin
      n_bad++; $display("FAIL lap_release: disp=%h lap=%b want 000015 0", dut_disp, lap_active);
    end
    // Lap on a tick edge captures the pre-tick value.
    cycle(0, 1, 0);
    repeat (DIV - 1) cycle(1, 0, 0);
    cycle(1, 0, 1);
    n_total++;
    if (dut_disp !== 24'h000000 || lap_active !== 1'b1) begin
      n_bad++; $display("FAIL lap_on_tick: disp=%h lap=%b want 000000 1", dut_disp, lap_active);
    end
    cycle(0, 0, 1);
    n_total++;
    if (dut_disp !== 24'h000001 || lap_active !== 1'b0) begin
      n_bad++; $display("FAIL lap_on_tick_live: disp=%h lap=%b want 000001 0", dut_disp, lap_active);
    end
  endtask

  task automatic test_clear_priority();
    cycle(0, 1, 0);
    repeat (7 * DIV + 2) cycle(1, 0, 0);
    cycle(1, 0, 1);
    repeat (DIV) cycle(1, 0, 0);
    cycle(1, 1, 1);
    n_total++;
    if (dut_disp !== 24'h0 || lap_active !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL clr_priority: disp=%h lap=%b ovf=%b want 000000 0 0", dut_disp, lap_active, overflow);
    end
    for (int i = 1; i <= DIV; i++) begin
      cycle(1, 0, 0);
      n_total++;
      if (dut_disp !== ((i == DIV) ? 24'h1 : 24'h0)) begin
        n_bad++; $display("FAIL clr_first_tick: cyc=%0d disp=%h", i, dut_disp);
      end
    end
  endtask

  task automatic test_random();
    bit r, c, l;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 29) == 0);
      cycle(r, c, l);
      n_total++;
      if (dut_disp !== m_disp() || lap_active !== m_lapact || overflow !== m_ovf()) begin
        n_bad++;
        $display("FAIL random: cyc=%0d disp=%h lap=%b ovf=%b want %h %b %b",
                 i, dut_disp, lap_active, overflow, m_disp(), m_lapact, m_ovf());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_rollover();
    test_lap();
    test_clear_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- Timekeeping datapath directly downstream of the stopwatch FSM controller; consumes its `run` and `clr` outputs.
- Divides the system clock into centisecond ticks and counts elapsed time as BCD digits MM:SS.cc.
- Provides a lap-hold function that freezes the displayed value while counting continues.
- Feeds the seven-segment display driver.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count resolution in Hz (centiseconds).
- DIV is derived as CLK_HZ/TICK_HZ; it must be an integer ≥ 1. A non-integer ratio or DIV < 1 is a configuration error, flagged by an elaboration-time check.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- run  input  1  count enable from the FSM controller.
- clr  input  1  synchronous clear from the FSM controller (level).
- lap  input  1  single-cycle lap pulse from the debounced lap button.
- min_tens  output  4  displayed minutes tens digit, BCD 0-5.
- min_ones  output  4  displayed minutes ones digit, BCD 0-9.
- sec_tens  output  4  displayed seconds tens digit, BCD 0-5.
- sec_ones  output  4  displayed seconds ones digit, BCD 0-9.
- cs_tens  output  4  displayed centiseconds tens digit, BCD 0-9.
- cs_ones  output  4  displayed centiseconds ones digit, BCD 0-9.
- lap_active  output  1  high while the display is frozen on a lap value.
- overflow  output  1  sticky flag, set on wrap past 59:59.99.

Behaviour:
- Reset (reset_n=0, asynchronous) forces:
  - prescaler = 0;
  - all live digits and all lap-latch digits = 0;
  - lap_active = 0, overflow = 0.
  - Reset is released synchronously to the design. Asserting it mid-count takes effect immediately, with no completion of the current tick.
- Priority each cycle: clr > run/lap.
- clr = 1 at a clock edge clears:
  - prescaler, live digits, lap latch;
  - lap_active and overflow.
  - No counting or lap action occurs while clr is high, even when run = 1.
- Prescaler:
  - Counts 0..DIV-1 only when run = 1 and clr = 0. The edge at which prescaler == DIV-1 generates an internal tick and returns the prescaler to 0.
  - With run = 0 it holds its value, so the fractional tick is preserved across pause and resume.
  - The first tick after clear arrives on the DIV-th enabled edge.
- Digit chain (live registers), advanced on each tick:
  - cs_ones wraps 9→0 and carries into cs_tens.
  - cs_tens wraps 9→0 and carries into sec_ones.
  - sec_ones wraps 9→0 and carries into sec_tens.
  - sec_tens wraps 5→0 and carries into min_ones.
  - min_ones wraps 9→0 and carries into min_tens.
  - min_tens wraps 5→0.
  - All carries resolve in the same edge.
- Wrap past 59:59.99: the tick at 59:59.99 yields 00:00.00 and sets overflow = 1. overflow stays set until clr or reset.
- Digit values are always legal BCD. No illegal code is reachable from reset.
- Lap, when lap = 1 and clr = 0:
  - If lap_active = 0: copy the live digits (their value before this edge's tick) into the lap latch and set lap_active = 1.
  - If lap_active = 1: clear lap_active. The lap latch keeps its value.
  - Lap is honoured regardless of run (a lap taken while paused is legal).
- Display outputs are combinational:
  - lap_active = 1 → outputs show the lap latch;
  - lap_active = 0 → outputs show the live digits.
  - Latency: a tick edge updates the live outputs in the same cycle it is registered; there is no extra pipeline stage.
- Live counting continues unaffected while lap_active = 1.

Test Plan (CLK_HZ=400, TICK_HZ=100 → DIV=4):
- Reset: hold reset_n=0 mid-run, then release → all digits 0, lap_active=0, overflow=0, with no tick for the next 3 enabled cycles.
- Basic count: run=1 for 400 cycles → display 00:01.00. At 6000×4 cycles → 01:00.00.
- Pause and resume: run=1 for 6 cycles, run=0 for 20, run=1 for 2 → cs_ones=2, proving the prescaler residual is retained.
- Rollover: run for 359999 ticks → 59:59.99, overflow=0. One more tick → 00:00.00, overflow=1. Then clr=1 for one cycle → overflow=0.
- Lap:
  - At 00:00.05, pulse lap → display stays 00:00.05 with lap_active=1 for 10 further ticks.
  - Pulse lap again → display 00:00.15, lap_active=0.
  - Lap on the same edge as a tick captures the pre-tick value.
- Clear priority: clr=1 with run=1 and lap=1 while lap_active=1 → next cycle all digits 0, lap_active=0, and no tick for 3 enabled cycles after clr drops.
